// File: rtl/bcd_operand_sequencer.sv
// rtl/bcd_operand_sequencer.sv - two-digit BCD adder front end: switch entry of A and B, debounced step key, registered BCD sum
module bcd_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic [7:0] sw_digits,
  input  logic       key_n,
  output logic [7:0] bcd_out,
  output logic       carry_out,
  output logic       digit_err,
  output logic [1:0] state_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    SHOW_SUM = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_sw_m, r_sw_s;
  logic            r_key_m, r_key_s;
  logic [CW-1:0]   r_cnt;
  logic            r_stable, r_stable_q, r_step;
  logic [7:0]      r_a, r_b;
  logic [7:0]      w_a_nxt, w_b_nxt, w_bcd_nxt;
  logic            w_carry_nxt, w_err_nxt;
  logic            w_sw_valid;
  logic [8:0]      w_sum;

  function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] s0, s1;
    logic       c0, c1;
    logic [3:0] d0, d1;
    s0 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c0 = (s0 > 5'd9);
    d0 = c0 ? (s0[3:0] + 4'd6) : s0[3:0];
    s1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, c0};
    c1 = (s1 > 5'd9);
    d1 = c1 ? (s1[3:0] + 4'd6) : s1[3:0];
    return {c1, d1, d0};
  endfunction

  assign w_sw_valid = (r_sw_s[7:4] <= 4'd9) && (r_sw_s[3:0] <= 4'd9);
  assign w_sum      = bcd_add(r_a, w_b_nxt);

  // Synchronizers and debouncer; the key idles released so a key held through reset counts as a press
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_sw_m     <= 8'h00;
      r_sw_s     <= 8'h00;
      r_key_m    <= 1'b1;
      r_key_s    <= 1'b1;
      r_cnt      <= '0;
      r_stable   <= 1'b1;
      r_stable_q <= 1'b1;
      r_step     <= 1'b0;
    end else begin
      r_sw_m     <= sw_digits;
      r_sw_s     <= r_sw_m;
      r_key_m    <= key_n;
      r_key_s    <= r_key_m;
      r_stable_q <= r_stable;
      r_step     <= r_stable_q & ~r_stable;
      if (r_key_s == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_key_s;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_state   <= ENTER_A;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      bcd_out   <= 8'h00;
      carry_out <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      bcd_out   <= w_bcd_nxt;
      carry_out <= w_carry_nxt;
      digit_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    if (r_step) begin
      case (r_state)
        ENTER_A: if (w_sw_valid) begin
          w_a_nxt     = r_sw_s;
          w_state_nxt = ENTER_B;
        end
        ENTER_B: if (w_sw_valid) begin
          w_b_nxt     = r_sw_s;
          w_state_nxt = SHOW_SUM;
        end
        default: w_state_nxt = ENTER_A;
      endcase
    end
  end

  // Output registers follow the state being entered; the sum freezes for the whole SHOW_SUM visit
  always_comb begin
    w_bcd_nxt   = r_sw_s;
    w_carry_nxt = 1'b0;
    w_err_nxt   = ~w_sw_valid;
    if (w_state_nxt == SHOW_SUM) begin
      w_err_nxt = 1'b0;
      if (r_state == ENTER_B) begin
        w_bcd_nxt   = w_sum[7:0];
        w_carry_nxt = w_sum[8];
      end else begin
        w_bcd_nxt   = bcd_out;
        w_carry_nxt = carry_out;
      end
    end
  end

  assign state_out = r_state;

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
// tb/tb_bcd_operand_sequencer.sv - directed bench for bcd_operand_sequencer with short debounce
module tb_bcd_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_digits;
  logic       key_n;
  logic [7:0] bcd_out;
  logic       carry_out;
  logic       digit_err;
  logic [1:0] state_out;

  int total = 0;
  int bad   = 0;

  bcd_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .sw_digits(sw_digits),
    .key_n(key_n),
    .bcd_out(bcd_out),
    .carry_out(carry_out),
    .digit_err(digit_err),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw_digits = v;
    tick(4);
  endtask

  task automatic add_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input logic exp_c);
    set_sw(a);
    press();
    check_val({tag, "_stB"}, 32'(state_out), 32'd1);
    set_sw(b);
    press();
    check_val({tag, "_stS"}, 32'(state_out), 32'd2);
    check_val({tag, "_sum"}, 32'(bcd_out), 32'(exp_sum));
    check_val({tag, "_cy"}, 32'(carry_out), 32'(exp_c));
    press();
    check_val({tag, "_back"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    sw_digits = 8'h00;
    key_n     = 1'b1;
    tick(2);
    check_val("rst_bcd", 32'(bcd_out), 32'h00);
    check_val("rst_st", 32'(state_out), 32'd0);
    check_val("rst_cy", 32'(carry_out), 32'd0);
    check_val("rst_err", 32'(digit_err), 32'd0);
    reset     = 1'b0;
    sw_digits = 8'h37;
    tick(3);
    check_val("echo_bcd", 32'(bcd_out), 32'h37);
    check_val("echo_st", 32'(state_out), 32'd0);
    check_val("echo_err", 32'(digit_err), 32'd0);
    check_val("echo_cy", 32'(carry_out), 32'd0);

    set_sw(8'h45);
    press();
    set_sw(8'h38);
    press();
    check_val("s83_st", 32'(state_out), 32'd2);
    check_val("s83_bcd", 32'(bcd_out), 32'h83);
    check_val("s83_cy", 32'(carry_out), 32'd0);
    sw_digits = 8'h11;
    tick(6);
    check_val("s83_frozen", 32'(bcd_out), 32'h83);
    check_val("s83_err", 32'(digit_err), 32'd0);
    press();
    check_val("s83_back", 32'(state_out), 32'd0);
    check_val("s83_echo", 32'(bcd_out), 32'h11);

    add_pair("s99", 8'h99, 8'h99, 8'h98, 1'b1);
    add_pair("s05", 8'h05, 8'h05, 8'h10, 1'b0);

    set_sw(8'h3A);
    check_val("bad_err", 32'(digit_err), 32'd1);
    check_val("bad_echo", 32'(bcd_out), 32'h3A);
    press();
    check_val("bad_st", 32'(state_out), 32'd0);
    set_sw(8'h12);
    check_val("fix_err", 32'(digit_err), 32'd0);
    press();
    check_val("fix_st", 32'(state_out), 32'd1);

    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(10);
    check_val("bounce_st", 32'(state_out), 32'd1);
    key_n = 1'b0;
    tick(20);
    check_val("hold_st", 32'(state_out), 32'd2);
    check_val("hold_sum", 32'(bcd_out), 32'h24);
    key_n = 1'b1;
    tick(12);
    check_val("release_st", 32'(state_out), 32'd2);
    press();
    check_val("rel_back", 32'(state_out), 32'd0);

    set_sw(8'h21);
    press();
    check_val("abort_pre", 32'(state_out), 32'd1);
    key_n = 1'b0;
    tick(4);
    reset = 1'b1;
    key_n = 1'b1;
    tick(1);
    check_val("abort_st", 32'(state_out), 32'd0);
    check_val("abort_bcd", 32'(bcd_out), 32'h00);
    check_val("abort_a", 32'(dut.r_a), 32'h00);
    check_val("abort_b", 32'(dut.r_b), 32'h00);
    reset = 1'b0;
    tick(15);
    check_val("abort_nostep", 32'(state_out), 32'd0);
    check_val("abort_echo", 32'(bcd_out), 32'h21);

    key_n = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(12);
    check_val("heldrst_st", 32'(state_out), 32'd1);
    key_n = 1'b1;
    tick(12);
    check_val("heldrst_once", 32'(state_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_operand_sequencer.md
Name: bcd_operand_sequencer

Overview:
- Upstream feeder for the two-digit BCD display stage on the DE10-Lite. It drives an 8-bit packed BCD bus (tens in [7:4], ones in [3:0]) that the display stage decodes onto HEX1/HEX0.
- A debounced push-button steps a three-state sequence: enter operand A from the switches, enter operand B, then show the registered BCD sum A+B with a hundreds carry.
- It turns the board into an interactive two-digit BCD adder.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clock cycles the synchronized key level must differ from the stable level before it is accepted (10 ms at 50 MHz). Legal range ≥2.

Ports:
- MAX10_CLK1_50  input  1  system clock, 50 MHz; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_digits  input  8  raw switch value, packed BCD, tens [7:4], ones [3:0]; asynchronous to the clock.
- key_n  input  1  raw step push-button, active-low, bouncy, asynchronous.
- bcd_out  output  8  packed BCD to the display stage.
- carry_out  output  1  hundreds digit of the sum; 0 outside SHOW_SUM.
- digit_err  output  1  the current switch value is not valid BCD in an entry state.
- state_out  output  2  00 ENTER_A, 01 ENTER_B, 10 SHOW_SUM; 11 is never driven.

Behaviour:
- Reset values (synchronous, applied on a clock edge with reset=1):
  - state ENTER_A.
  - bcd_out 8'h00, carry_out 0, digit_err 0, state_out 00.
  - Operand registers A and B 8'h00.
  - Debounce counter 0, stable key level 1 (released), step pulse 0.
- Input synchronization: sw_digits and key_n each pass through a 2-flop synchronizer. All downstream logic uses the synchronized copies (sw_s, key_s).
- Debounce:
  - If key_s equals the stable level, the counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 while key_s still differs, the stable level takes key_s and the counter clears.
  - Any return to the stable level before then clears the counter, so a glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Step pulse:
  - A registered, one-cycle pulse, asserted in the cycle after the stable level changes 1→0 (press).
  - Release never generates a step. Holding the key produces exactly one step.
  - A key held across reset deassertion is treated as a fresh press and yields exactly one step after debounce.
- Validity: sw_valid = (sw_s[7:4] ≤ 9) and (sw_s[3:0] ≤ 9).
- FSM, evaluated in a step cycle:
  - ENTER_A: if sw_valid, A ← sw_s and go to ENTER_B. Otherwise the step is ignored and the state holds.
  - ENTER_B: if sw_valid, B ← sw_s and load the sum registers from A + sw_s in the same edge, then go to SHOW_SUM. Otherwise the step is ignored.
  - SHOW_SUM: go to ENTER_A. A and B keep their values; they are overwritten only by later entries.
  - With no step, the state holds.
- BCD addition:
  - Ones: s0 = A[3:0] + B[3:0] (5 bits). If s0 > 9, the ones digit is s0+6 (low 4 bits) and c0 = 1; otherwise c0 = 0.
  - Tens: the same rule applied to A[7:4] + B[7:4] + c0, producing c1.
  - carry_out = c1. The maximum case 99+99 gives bcd_out 8'h98 with carry_out 1.
- Outputs, all registered:
  - ENTER_A / ENTER_B: bcd_out ← sw_s every cycle (live echo); carry_out ← 0; digit_err ← ~sw_valid.
  - SHOW_SUM: bcd_out and carry_out hold the sum computed at entry, frozen against switch changes; digit_err ← 0.
  - state_out reflects the registered state.
- Latency:
  - Switch change to bcd_out echo: 3 cycles (2 sync + 1 output register).
  - key_n press (clean edge) to step pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Step to new state_out, and to the sum on bcd_out: 1 cycle.
- Simultaneous events:
  - reset dominates everything.
  - A switch change in the same cycle as a step: the step samples the sw_s present in that cycle.
- Reset mid-operation (any state, mid-debounce): return to all reset values on the next edge. Partial operands are discarded.

Test Plan (DEBOUNCE_CYCLES=4 in bench):
- Reset, then SW=8'h37 → after 3 cycles bcd_out=8'h37, state_out=00, digit_err=0, carry_out=0.
- A=8'h45 then B=8'h38, each entered by a clean press held 10 cycles → state_out=10, bcd_out=8'h83, carry_out=0. Then change SW to 8'h11 → bcd_out stays 8'h83.
- A=8'h99, B=8'h99 → bcd_out=8'h98, carry_out=1. A=8'h05, B=8'h05 → bcd_out=8'h10, carry_out=0.
- In ENTER_A set SW=8'h3A and press → digit_err=1, state_out stays 00, no latch. Then SW=8'h12 → digit_err=0, and the next press moves to ENTER_B.
- key_n bounces (low 2 cycles, high 1, low 3, high) and no press is ever stable for 4 cycles → no step. Then low for 20 cycles → exactly one step, and release generates none.
- In ENTER_B with a press mid-debounce, assert reset for 1 cycle → state_out=00, bcd_out=8'h00, A=B=0, and no step from the aborted press.
